psram_ctrl: RTL and testbench
=============================

# psram_ctrl

Parametrised asynchronous-mode controller for the board's cellular RAM (PSRAM), the successor to the fixed single-word `ram` block. It accepts single-word read/write requests through a valid/ack handshake with byte enables. It generates the chip control strobes with configurable access and recovery timing, and returns read data with a one-cycle valid pulse. It sits between `top` (or a synth sample engine) and the external memory pins.

## Interface
- `ADDR_W`, 23, word address width.
- `DATA_W`, 16, data width; must be a multiple of 8; byte lanes `BE_W = DATA_W/8`.
- `WAIT_CYC`, 7, cycles the OE/WE strobe is held low (≥70 ns at `clk`); must be ≥1.
- `RECOV_CYC`, 1, cycles CS is held high between accesses; must be ≥1.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset.
- `req`  in  1  request valid; held until `ack`.
- `we`  in  1  1 = write, 0 = read; sampled with `req`.
- `addr`  in  ADDR_W  word address.
- `wdata`  in  DATA_W  write data.
- `be`  in  BE_W  byte enables, active-high.
- `ack`  out  1  one-cycle pulse: request accepted.
- `busy`  out  1  high from acceptance until the controller is back in IDLE.
- `rdata`  out  DATA_W  read data; holds its last value.
- `rvalid`  out  1  one-cycle pulse: `rdata` is new.
- `ram_adv_n`, `ram_clk`  out  1  tied 0 (async mode).
- `ram_cs_n`, `mem_oe_n`, `mem_we_n`  out  1  active-low strobes.
- `ram_lb_n`, `ram_ub_n`  out  1 each  active-low byte lanes (BE_W = 2 mapping; wider DATA_W uses bank bits of `be`).
- `mem_adr`  out  ADDR_W  address, registered.
- `mem_db`  inout  DATA_W  data bus; tristated except during write.

## Operation
- FSM states: IDLE, SETUP, ACCESS, RECOV.
- IDLE: `req`=1 at an edge → latch `we`, `addr`, `wdata`, `be`; pulse `ack`; go to SETUP. `busy`=0 only in IDLE.
- SETUP (1 cycle): `ram_cs_n`=0, `mem_adr` and lane strobes valid. On a write, drive `mem_db`.
- ACCESS (`WAIT_CYC` cycles, down-counter): `mem_oe_n`=0 (read) or `mem_we_n`=0 (write). A read captures `mem_db` into `rdata` at the last ACCESS edge.
- RECOV (`RECOV_CYC` cycles): all strobes high. Write data stays driven for the first RECOV cycle (hold), then is tristated. At RECOV exit, go to IDLE.
- Lane strobes follow latched `be` for both reads and writes. A read with `be`=0 still runs and returns bus contents.
- A `req` arriving while `busy` is ignored until IDLE; the requester holds it.
- Reset (any time, including mid-access): all strobes high, `mem_db` tristated, `ack`=`rvalid`=`busy`=0, `rdata`=0, `mem_adr`=0, state IDLE. The in-flight transaction is dropped with no `rvalid`.

## Timing
- With acceptance at edge 0: SETUP during cycle 1, ACCESS during cycles 2..1+WAIT_CYC, and `rvalid` high during cycle 2+WAIT_CYC.
- Occupancy is 1+WAIT_CYC+RECOV_CYC cycles. With the defaults this is 9 cycles, so back-to-back requests are accepted every 10 cycles (9 + IDLE).
- Every output is registered; there are no combinational paths from `req` to pins.

## Configuration
- `PSRAM_CTRL_BURST_EN` defined: adds input `burst` (1 bit, sampled with `req`). When set, the controller performs 4 consecutive accesses at `addr`, `addr+1`, `addr+2`, `addr+3`:
  - Each access is SETUP/ACCESS/RECOV.
  - The address wraps modulo 2^ADDR_W.
  - Reads give one `rvalid` per word.
  - Writes take new `wdata` on each `ack`. `ack` pulses once per word, at acceptance and at each RECOV exit that starts the next word.
  - `busy` stays high for the whole burst.
- Undefined: no `burst` port; single-word behaviour only.

## Structure
- Package `psram_pkg` holds the state enum `psram_state_t` and the default timing constants (`PSRAM_WAIT_CYC_DEF`, `PSRAM_RECOV_CYC_DEF`).
- There are no sub-modules. The tristate is an inline assign on `mem_db` controlled by a registered drive-enable.

## Test plan
- Reset, then write `addr`=0x000010, `wdata`=0xBEEF, `be`=2'b11 → `mem_we_n` low for exactly 7 cycles, `ram_lb_n`=`ram_ub_n`=0, and the bus model stores 0xBEEF.
- Read 0x000010 → `rvalid` pulses at cycle 9 after acceptance, `rdata`=0xBEEF, and `mem_db` is never driven by the controller.
- Write 0x12 with `be`=2'b01 over a stored 0xBEEF → `ram_ub_n` stays high, and a readback gives 0xBE12.
- Hold `req` continuously for 3 reads → exactly 3 `ack` pulses, 10 cycles apart, and `busy` stays low for 1 cycle between them.
- Assert `rst` low during ACCESS of a read → strobes go high and the bus tristates immediately, with no `rvalid`. After release the next request completes normally.
- With `PSRAM_CTRL_BURST_EN`: burst read at 0x7FFFFE → addresses 0x7FFFFE, 0x7FFFFF, 0x000000, 0x000001 and 4 `rvalid` pulses.

Source files
------------

// File: rtl/psram_pkg.sv
// Shared types and default timing for the async-mode PSRAM controller.
package psram_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RECOV
  } psram_state_t;

  localparam int PSRAM_WAIT_CYC_DEF  = 7;
  localparam int PSRAM_RECOV_CYC_DEF = 1;

endpackage

// File: rtl/psram_ctrl.sv
// Async-mode cellular RAM controller: single-word valid/ack requests.
// Define PSRAM_CTRL_BURST_EN to add a 4-word incrementing burst.
module psram_ctrl
  import psram_pkg::*;
#(
  parameter int ADDR_W    = 23,
  parameter int DATA_W    = 16,
  parameter int BE_W      = DATA_W / 8,
  parameter int WAIT_CYC  = PSRAM_WAIT_CYC_DEF,
  parameter int RECOV_CYC = PSRAM_RECOV_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst,
`ifdef PSRAM_CTRL_BURST_EN
  input  logic              burst,
`endif
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [BE_W-1:0]   be,
  output logic              ack,
  output logic              busy,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              ram_adv_n,
  output logic              ram_clk,
  output logic              ram_cs_n,
  output logic              mem_oe_n,
  output logic              mem_we_n,
  output logic              ram_lb_n,
  output logic              ram_ub_n,
  output logic [ADDR_W-1:0] mem_adr,
  inout  wire  [DATA_W-1:0] mem_db
);

  localparam int MAX_CYC = (WAIT_CYC > RECOV_CYC) ?
                           WAIT_CYC : RECOV_CYC;
  localparam int CNT_W = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] WAIT_LD  = CNT_W'(WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] RECOV_LD = CNT_W'(RECOV_CYC - 1);

  psram_state_t      state;
  logic [CNT_W-1:0]  cnt;
  logic              we_q;
  logic [BE_W-1:0]   be_q;
  logic [DATA_W-1:0] dout;
  logic              de;
  logic              more;

  // Lower half of the byte enables drives LB, upper half drives UB.
  function automatic logic [1:0] lanes_n(input logic [BE_W-1:0] b);
    logic lo;
    logic hi;
    lo = 1'b0;
    hi = 1'b0;
    for (int i = 0; i < BE_W; i++) begin
      if (i < (BE_W + 1) / 2) lo = lo | b[i];
      else                    hi = hi | b[i];
    end
    return {~hi, ~lo};
  endfunction

`ifdef PSRAM_CTRL_BURST_EN
  logic       burst_q;
  logic [1:0] bcnt;
  assign more = burst_q && (bcnt != 2'd3);
`else
  assign more = 1'b0;
`endif

  assign ram_adv_n = 1'b0;
  assign ram_clk   = 1'b0;
  assign mem_db    = de ? dout : {DATA_W{1'bz}};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      we_q     <= 1'b0;
      be_q     <= '0;
      dout     <= '0;
      de       <= 1'b0;
      ack      <= 1'b0;
      busy     <= 1'b0;
      rdata    <= '0;
      rvalid   <= 1'b0;
      ram_cs_n <= 1'b1;
      mem_oe_n <= 1'b1;
      mem_we_n <= 1'b1;
      ram_lb_n <= 1'b1;
      ram_ub_n <= 1'b1;
      mem_adr  <= '0;
`ifdef PSRAM_CTRL_BURST_EN
      burst_q  <= 1'b0;
      bcnt     <= 2'd0;
`endif
    end else begin
      ack    <= 1'b0;
      rvalid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req) begin
            we_q     <= we;
            be_q     <= be;
            dout     <= wdata;
            mem_adr  <= addr;
            de       <= we;
            ack      <= 1'b1;
            busy     <= 1'b1;
            ram_cs_n <= 1'b0;
            {ram_ub_n, ram_lb_n} <= lanes_n(be);
`ifdef PSRAM_CTRL_BURST_EN
            burst_q  <= burst;
            bcnt     <= 2'd0;
`endif
            state    <= SETUP;
          end
        end
        SETUP: begin
          cnt      <= WAIT_LD;
          mem_oe_n <= we_q;
          mem_we_n <= ~we_q;
          state    <= ACCESS;
        end
        ACCESS: begin
          if (cnt == '0) begin
            ram_cs_n <= 1'b1;
            mem_oe_n <= 1'b1;
            mem_we_n <= 1'b1;
            ram_lb_n <= 1'b1;
            ram_ub_n <= 1'b1;
            if (!we_q) begin
              rdata  <= mem_db;
              rvalid <= 1'b1;
            end
            cnt   <= RECOV_LD;
            state <= RECOV;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RECOV: begin
          // Write data is held only through the first recovery cycle.
          de <= 1'b0;
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (more) begin
            mem_adr  <= mem_adr + 1'b1;
            ack      <= 1'b1;
            ram_cs_n <= 1'b0;
            if (we_q) begin
              dout <= wdata;
              be_q <= be;
              de   <= 1'b1;
              {ram_ub_n, ram_lb_n} <= lanes_n(be);
            end else begin
              {ram_ub_n, ram_lb_n} <= lanes_n(be_q);
            end
`ifdef PSRAM_CTRL_BURST_EN
            bcnt <= bcnt + 2'd1;
`endif
            state <= SETUP;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_psram_ctrl.sv
// Directed self-checking bench for psram_ctrl with a behavioural PSRAM.
// Burst scenario is built only when PSRAM_CTRL_BURST_EN is defined.
module tb_psram_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [22:0] addr = '0;
  logic [15:0] wdata = '0;
  logic [1:0]  be = '0;
`ifdef PSRAM_CTRL_BURST_EN
  logic        burst = 1'b0;
`endif
  logic        ack;
  logic        busy;
  logic [15:0] rdata;
  logic        rvalid;
  logic        ram_adv_n;
  logic        ram_clk;
  logic        ram_cs_n;
  logic        mem_oe_n;
  logic        mem_we_n;
  logic        ram_lb_n;
  logic        ram_ub_n;
  logic [22:0] mem_adr;
  tri   [15:0] mem_db;

  int checks = 0;
  int errors = 0;

  psram_ctrl dut (
    .clk       (clk),
    .rst       (rst),
`ifdef PSRAM_CTRL_BURST_EN
    .burst     (burst),
`endif
    .req       (req),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .be        (be),
    .ack       (ack),
    .busy      (busy),
    .rdata     (rdata),
    .rvalid    (rvalid),
    .ram_adv_n (ram_adv_n),
    .ram_clk   (ram_clk),
    .ram_cs_n  (ram_cs_n),
    .mem_oe_n  (mem_oe_n),
    .mem_we_n  (mem_we_n),
    .ram_lb_n  (ram_lb_n),
    .ram_ub_n  (ram_ub_n),
    .mem_adr   (mem_adr),
    .mem_db    (mem_db)
  );

  always #5 clk = ~clk;

  // Behavioural memory: unwritten words read as 0x5A00 | addr[7:0].
  logic [15:0] mem [logic [22:0]];
  logic        drv = 1'b0;
  logic [15:0] drv_val = '0;

  function automatic logic [15:0] rd_word(input logic [22:0] a);
    if (mem.exists(a)) return mem[a];
    return 16'h5A00 | {8'h00, a[7:0]};
  endfunction

  assign mem_db = drv ? drv_val : 16'hzzzz;

  always @(negedge clk) begin
    logic [15:0] cur;
    drv     <= rst && !ram_cs_n && !mem_oe_n;
    drv_val <= rd_word(mem_adr);
    if (rst && !ram_cs_n && !mem_we_n) begin
      cur = rd_word(mem_adr);
      if (!ram_lb_n) cur[7:0] = mem_db[7:0];
      if (!ram_ub_n) cur[15:8] = mem_db[15:8];
      mem[mem_adr] = cur;
    end
  end

  task automatic wait_ack(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ack) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s: ack timeout, got none, required one", name);
    end
  endtask

  task automatic run_txn(
    input  string       name,
    input  bit          w,
    input  logic [22:0] a,
    input  logic [15:0] d,
    input  logic [1:0]  b,
    output int          we_low,
    output int          oe_low,
    output int          lb_low,
    output int          ub_low,
    output int          rv_cyc,
    output int          rv_cnt,
    output logic [15:0] rd
  );
    we_low = 0; oe_low = 0; lb_low = 0; ub_low = 0;
    rv_cyc = 0; rv_cnt = 0; rd = '0;
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d; be = b;
    wait_ack(name);
    req = 1'b0;
    for (int n = 1; n <= 14; n++) begin
      if (n > 1) @(negedge clk);
      if (!mem_we_n) we_low++;
      if (!mem_oe_n) oe_low++;
      if (!ram_lb_n) lb_low++;
      if (!ram_ub_n) ub_low++;
      if (rvalid) begin
        rv_cnt++;
        if (rv_cyc == 0) rv_cyc = n;
        rd = rdata;
      end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if ({ram_cs_n, mem_oe_n, mem_we_n, ram_lb_n, ram_ub_n} !== 5'b11111) begin
      errors++;
      $display("FAIL reset_strobes: got %b, required 11111",
               {ram_cs_n, mem_oe_n, mem_we_n, ram_lb_n, ram_ub_n});
    end
    checks++;
    if ({ack, rvalid, busy, ram_adv_n, ram_clk} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_flags: got %b, required 00000",
               {ack, rvalid, busy, ram_adv_n, ram_clk});
    end
    checks++;
    if (rdata !== 16'h0 || mem_adr !== 23'h0) begin
      errors++;
      $display("FAIL reset_data: rdata %h adr %h, required 0 0",
               rdata, mem_adr);
    end
    rst = 1'b1;
  endtask

  task automatic test_write;
    int wl, ol, ll, ul, rc, rn;
    logic [15:0] rd;
    run_txn("write", 1'b1, 23'h10, 16'hBEEF, 2'b11,
            wl, ol, ll, ul, rc, rn, rd);
    checks++;
    if (wl !== 7) begin
      errors++;
      $display("FAIL write_we_len: got %0d cycles, required 7", wl);
    end
    checks++;
    if (ol !== 0 || rn !== 0) begin
      errors++;
      $display("FAIL write_no_read: oe %0d rvalid %0d, required 0 0",
               ol, rn);
    end
    checks++;
    if (ll !== 8 || ul !== 8) begin
      errors++;
      $display("FAIL write_lanes: lb %0d ub %0d, required 8 8", ll, ul);
    end
    checks++;
    if (rd_word(23'h10) !== 16'hBEEF) begin
      errors++;
      $display("FAIL write_stored: got %h, required beef",
               rd_word(23'h10));
    end
  endtask

  task automatic test_read;
    int wl, ol, ll, ul, rc, rn;
    logic [15:0] rd;
    run_txn("read", 1'b0, 23'h10, 16'h0000, 2'b11,
            wl, ol, ll, ul, rc, rn, rd);
    checks++;
    if (rc !== 9 || rn !== 1) begin
      errors++;
      $display("FAIL read_rvalid: cycle %0d count %0d, required 9 1",
               rc, rn);
    end
    checks++;
    if (rd !== 16'hBEEF) begin
      errors++;
      $display("FAIL read_data: got %h, required beef", rd);
    end
    checks++;
    if (ol !== 7 || wl !== 0) begin
      errors++;
      $display("FAIL read_oe_len: oe %0d we %0d, required 7 0", ol, wl);
    end
    checks++;
    if (rdata !== 16'hBEEF) begin
      errors++;
      $display("FAIL read_hold: got %h, required beef", rdata);
    end
  endtask

  task automatic test_partial;
    int wl, ol, ll, ul, rc, rn;
    logic [15:0] rd;
    run_txn("partial_wr", 1'b1, 23'h10, 16'h0012, 2'b01,
            wl, ol, ll, ul, rc, rn, rd);
    checks++;
    if (ul !== 0 || ll !== 8 || wl !== 7) begin
      errors++;
      $display("FAIL partial_lanes: ub %0d lb %0d we %0d, required 0 8 7",
               ul, ll, wl);
    end
    run_txn("partial_rd", 1'b0, 23'h10, 16'h0000, 2'b11,
            wl, ol, ll, ul, rc, rn, rd);
    checks++;
    if (rd !== 16'hBE12) begin
      errors++;
      $display("FAIL partial_readback: got %h, required be12", rd);
    end
  endtask

  task automatic test_back_to_back;
    int at [3];
    int acks;
    int gap;
    acks = 0;
    gap  = 0;
    at   = '{0, 0, 0};
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 23'h10; be = 2'b11;
    for (int t = 1; t <= 40; t++) begin
      @(negedge clk);
      if (ack) begin
        at[acks] = t;
        acks++;
        if (acks == 3) break;
      end else if (acks == 1 && !busy) begin
        gap++;
      end
    end
    req = 1'b0;
    checks++;
    if (acks !== 3) begin
      errors++;
      $display("FAIL b2b_acks: got %0d, required 3", acks);
    end
    checks++;
    if (at[1] - at[0] !== 10 || at[2] - at[1] !== 10) begin
      errors++;
      $display("FAIL b2b_spacing: got %0d %0d, required 10 10",
               at[1] - at[0], at[2] - at[1]);
    end
    checks++;
    if (gap !== 1) begin
      errors++;
      $display("FAIL b2b_idle_gap: got %0d, required 1", gap);
    end
    repeat (14) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int rn;
    int wl, ol, ll, ul, rc;
    logic [15:0] rd;
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 23'h10; be = 2'b11;
    wait_ack("rst_mid");
    req = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (mem_oe_n !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_pre: oe_n %b, required 0", mem_oe_n);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({ram_cs_n, mem_oe_n, mem_we_n, ram_lb_n, ram_ub_n} !== 5'b11111 ||
        busy !== 1'b0 || mem_adr !== 23'h0) begin
      errors++;
      $display("FAIL rst_mid_strobes: got %b busy %b adr %h, required 11111 0 0",
               {ram_cs_n, mem_oe_n, mem_we_n, ram_lb_n, ram_ub_n},
               busy, mem_adr);
    end
    @(negedge clk);
    rst = 1'b1;
    rn = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (rvalid) rn++;
    end
    checks++;
    if (rn !== 0 || rdata !== 16'h0) begin
      errors++;
      $display("FAIL rst_mid_drop: rvalid %0d rdata %h, required 0 0",
               rn, rdata);
    end
    run_txn("rst_after", 1'b0, 23'h10, 16'h0000, 2'b11,
            wl, ol, ll, ul, rc, rn, rd);
    checks++;
    if (rd !== 16'hBE12 || rc !== 9) begin
      errors++;
      $display("FAIL rst_after_read: data %h cycle %0d, required be12 9",
               rd, rc);
    end
  endtask

`ifdef PSRAM_CTRL_BURST_EN
  task automatic test_burst;
    logic [22:0] exp_a [4];
    logic [22:0] seen_a [4];
    int na, rv, acks, bad;
    logic prev_cs;
    exp_a = '{23'h7FFFFE, 23'h7FFFFF, 23'h000000, 23'h000001};
    seen_a = '{default: '0};
    na = 0; rv = 0; acks = 0; bad = 0;
    prev_cs = 1'b1;
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 23'h7FFFFE; be = 2'b11; burst = 1'b1;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (ack) begin
        acks++;
        req = 1'b0;
        burst = 1'b0;
      end
      if (!ram_cs_n && prev_cs) begin
        if (na < 4) seen_a[na] = mem_adr;
        na++;
      end
      prev_cs = ram_cs_n;
      if (rvalid) begin
        if (rv < 4 && rdata !== rd_word(exp_a[rv])) bad++;
        rv++;
      end
    end
    checks++;
    if (na !== 4 || acks !== 4 || rv !== 4) begin
      errors++;
      $display("FAIL burst_counts: words %0d acks %0d rvalid %0d, required 4 4 4",
               na, acks, rv);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (seen_a[i] !== exp_a[i]) begin
        errors++;
        $display("FAIL burst_addr%0d: got %h, required %h",
                 i, seen_a[i], exp_a[i]);
      end
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL burst_data: %0d wrong words, required 0", bad);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_read();
    test_partial();
    test_back_to_back();
    test_reset_mid();
`ifdef PSRAM_CTRL_BURST_EN
    test_burst();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
